// File: rtl/lfu_cache_pkg.sv
// Shared types and default sizing for the LFU set-associative cache.
// Op codes, FSM states and parameter defaults used by the top and bench.
package lfu_cache_pkg;

  localparam int DEF_SET_BITS  = 6;
  localparam int DEF_TAG_BITS  = 8;
  localparam int DEF_WAYS      = 4;
  localparam int DEF_LINE_BITS = 64;
  localparam int DEF_CNT_BITS  = 4;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RESP  = 2'b01,
    S_FLUSH = 2'b10
  } state_e;

endpackage

// File: rtl/lfu_victim_sel.sv
// Combinational victim picker: lowest invalid way, else lowest-index min count.
// Ports: valid_i/cnt_i (flattened per way) in; victim_o, victim_was_valid_o out.
module lfu_victim_sel #(
  parameter int WAYS     = 4,
  parameter int CNT_BITS = 4
) (
  input  logic [WAYS-1:0]          valid_i,
  input  logic [WAYS*CNT_BITS-1:0] cnt_i,
  output logic [$clog2(WAYS)-1:0]  victim_o,
  output logic                     victim_was_valid_o
);

  localparam int WW = $clog2(WAYS);

  logic          inv_found;
  logic [WW-1:0] inv_way;
  logic [WW-1:0] min_way;
  logic [CNT_BITS-1:0] min_cnt;

  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    min_way   = '0;
    min_cnt   = cnt_i[CNT_BITS-1:0];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    end
    // strict < keeps the lowest index on ties
    for (int w = 1; w < WAYS; w++) begin
      if (cnt_i[w*CNT_BITS +: CNT_BITS] < min_cnt) begin
        min_cnt = cnt_i[w*CNT_BITS +: CNT_BITS];
        min_way = WW'(w);
      end
    end
    victim_o           = inv_found ? inv_way : min_way;
    victim_was_valid_o = !inv_found;
  end

endmodule

// File: rtl/lfu_set_cache.sv
// N-way set-associative line store with saturating LFU counters and flush.
// Ports: req_* handshake in, resp_*/evict_* response out, flush/busy control.
module lfu_set_cache
  import lfu_cache_pkg::*;
#(
  parameter int SET_BITS  = DEF_SET_BITS,
  parameter int TAG_BITS  = DEF_TAG_BITS,
  parameter int WAYS      = DEF_WAYS,
  parameter int LINE_BITS = DEF_LINE_BITS,
  parameter int CNT_BITS  = DEF_CNT_BITS
) (
  input  logic                              clk,
  input  logic                              gen_reset_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [1:0]                        req_op,
  input  logic [TAG_BITS+SET_BITS-1:0]      req_addr,
  input  logic [$clog2(LINE_BITS/16)-1:0]   req_lane,
  input  logic [LINE_BITS-1:0]              req_data,
  input  logic                              flush,
  output logic                              busy,
  output logic                              resp_valid,
  output logic                              resp_hit,
  output logic [LINE_BITS-1:0]              resp_data,
  output logic [$clog2(WAYS)-1:0]           resp_way,
  output logic                              evict_valid,
  output logic [TAG_BITS-1:0]               evict_tag
);

  localparam int NUM_SETS  = 2**SET_BITS;
  localparam int ADDR_BITS = TAG_BITS + SET_BITS;
  localparam int LW        = $clog2(LINE_BITS/16);
  localparam int WW        = $clog2(WAYS);
  localparam int CNT_MAX   = 2**CNT_BITS - 1;

  state_e state_q, state_d;
  logic [SET_BITS-1:0]  fidx_q;
  logic [1:0]           op_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [LW-1:0]        lane_q;
  logic [LINE_BITS-1:0] data_q;

  logic [LINE_BITS-1:0] line_q  [NUM_SETS][WAYS];
  logic [TAG_BITS-1:0]  tag_q   [NUM_SETS][WAYS];
  logic [WAYS-1:0]      valid_q [NUM_SETS];
  logic [CNT_BITS-1:0]  cnt_q   [NUM_SETS][WAYS];

  logic                 resp_valid_q, resp_hit_q;
  logic [LINE_BITS-1:0] resp_data_q;
  logic [WW-1:0]        resp_way_q;
  logic                 evict_valid_q;
  logic [TAG_BITS-1:0]  evict_tag_q;

  logic [SET_BITS-1:0]      set_w;
  logic [TAG_BITS-1:0]      tag_w;
  logic                     hit;
  logic [WW-1:0]            hit_way;
  logic [WAYS*CNT_BITS-1:0] cnt_flat;
  logic [CNT_BITS-1:0]      cur_cnt;
  logic [CNT_BITS-1:0]      cnt_new [WAYS];
  logic [WW-1:0]            victim;
  logic                     victim_was_valid;
  logic                     is_fill, is_write, is_read, evict;

  assign set_w    = addr_q[SET_BITS-1:0];
  assign tag_w    = addr_q[ADDR_BITS-1:SET_BITS];
  assign is_fill  = (op_q == OP_FILL);
  assign is_write = (op_q == OP_WRITE);
  assign is_read  = !is_fill && !is_write;
  assign evict    = is_fill && !hit && victim_was_valid;

  // flush wins: a pending request stays unaccepted
  assign req_ready = (state_q == S_IDLE) && !flush;
  assign busy      = (state_q == S_FLUSH);

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      cnt_flat[w*CNT_BITS +: CNT_BITS] = cnt_q[set_w][w];
      if (valid_q[set_w][w] && tag_q[set_w][w] == tag_w) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  // saturation ages the whole set instead of wrapping
  always_comb begin
    cur_cnt = cnt_q[set_w][hit_way];
    for (int w = 0; w < WAYS; w++) cnt_new[w] = cnt_q[set_w][w];
    if (cur_cnt == CNT_BITS'(CNT_MAX)) begin
      for (int w = 0; w < WAYS; w++) cnt_new[w] = cnt_q[set_w][w] >> 1;
      cnt_new[hit_way] = CNT_BITS'((CNT_MAX >> 1) + 1);
    end else begin
      cnt_new[hit_way] = cur_cnt + 1'b1;
    end
  end

  lfu_victim_sel #(
    .WAYS     (WAYS),
    .CNT_BITS (CNT_BITS)
  ) u_victim (
    .valid_i            (valid_q[set_w]),
    .cnt_i              (cnt_flat),
    .victim_o           (victim),
    .victim_was_valid_o (victim_was_valid)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (flush) state_d = S_FLUSH;
        else if (req_valid) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      S_FLUSH: begin
        if (fidx_q == SET_BITS'(NUM_SETS - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge gen_reset_n) begin
    if (!gen_reset_n) begin
      state_q <= S_IDLE;
      fidx_q  <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      lane_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FLUSH) fidx_q <= fidx_q + 1'b1;
      else fidx_q <= '0;
      if (req_valid && req_ready) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        lane_q <= req_lane;
        data_q <= req_data;
      end
    end
  end

  always_ff @(posedge clk or negedge gen_reset_n) begin
    if (!gen_reset_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) cnt_q[s][w] <= '0;
      end
    end else if (state_q == S_FLUSH) begin
      valid_q[fidx_q] <= '0;
      for (int w = 0; w < WAYS; w++) cnt_q[fidx_q][w] <= '0;
    end else if (state_q == S_RESP) begin
      if (hit && !is_fill) begin
        for (int w = 0; w < WAYS; w++) cnt_q[set_w][w] <= cnt_new[w];
      end else if (!hit && is_fill) begin
        valid_q[set_w][victim] <= 1'b1;
        cnt_q[set_w][victim]   <= CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_RESP) begin
      if (is_fill && hit) begin
        line_q[set_w][hit_way] <= data_q;
      end else if (is_fill) begin
        line_q[set_w][victim] <= data_q;
        tag_q[set_w][victim]  <= tag_w;
      end else if (is_write && hit) begin
        line_q[set_w][hit_way][lane_q*16 +: 16] <= data_q[15:0];
      end
    end
  end

  always_ff @(posedge clk or negedge gen_reset_n) begin
    if (!gen_reset_n) begin
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_data_q   <= '0;
      resp_way_q    <= '0;
      evict_valid_q <= 1'b0;
      evict_tag_q   <= '0;
    end else begin
      resp_valid_q <= (state_q == S_RESP);
      if (state_q == S_RESP) begin
        resp_hit_q    <= hit;
        resp_data_q   <= (hit && is_read) ? line_q[set_w][hit_way] : '0;
        resp_way_q    <= hit ? hit_way : (is_fill ? victim : '0);
        evict_valid_q <= evict;
        evict_tag_q   <= evict ? tag_q[set_w][victim] : '0;
      end
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_hit_q;
  assign resp_data   = resp_data_q;
  assign resp_way    = resp_way_q;
  assign evict_valid = evict_valid_q;
  assign evict_tag   = evict_tag_q;

endmodule

// File: tb/tb_lfu_set_cache.sv
// Directed bench for lfu_set_cache: fills, reads, writes, LFU eviction,
// aging, flush and reset-during-flush with hand-computed expectations.
module tb_lfu_set_cache;

  logic        clk = 1'b0;
  logic        gen_reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [13:0] req_addr;
  logic [1:0]  req_lane;
  logic [63:0] req_data;
  logic        flush;
  logic        busy;
  logic        resp_valid;
  logic        resp_hit;
  logic [63:0] resp_data;
  logic [1:0]  resp_way;
  logic        evict_valid;
  logic [7:0]  evict_tag;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int tot_cnt  = 0;

  logic        r_hit;
  logic [63:0] r_data;
  logic [1:0]  r_way;
  logic        r_ev;
  logic [7:0]  r_evtag;

  always #5 clk = ~clk;

  lfu_set_cache dut (
    .clk         (clk),
    .gen_reset_n (gen_reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_lane    (req_lane),
    .req_data    (req_data),
    .flush       (flush),
    .busy        (busy),
    .resp_valid  (resp_valid),
    .resp_hit    (resp_hit),
    .resp_data   (resp_data),
    .resp_way    (resp_way),
    .evict_valid (evict_valid),
    .evict_tag   (evict_tag)
  );

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    tot_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tot_cnt++;
    fail_cnt++;
    $error("FAIL %s: timed out, expected response", name);
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) timeout_fail("resp_wait");
    r_hit   = resp_hit;
    r_data  = resp_data;
    r_way   = resp_way;
    r_ev    = evict_valid;
    r_evtag = evict_tag;
  endtask

  task automatic req(input logic [1:0] op, input logic [7:0] tag,
                     input logic [5:0] set, input logic [1:0] lane,
                     input logic [63:0] data);
    int n;
    @(negedge clk);
    req_op    = op;
    req_addr  = {tag, set};
    req_lane  = lane;
    req_data  = data;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) timeout_fail("accept_wait");
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp();
  endtask

  task automatic rd(input logic [7:0] tag, input logic [5:0] set);
    req(2'b00, tag, set, 2'd0, 64'd0);
  endtask

  task automatic fill(input logic [7:0] tag, input logic [5:0] set,
                      input logic [63:0] data);
    req(2'b10, tag, set, 2'd0, data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic seen;
    gen_reset_n = 1'b0;
    req_valid   = 1'b0;
    req_op      = 2'b00;
    req_addr    = '0;
    req_lane    = '0;
    req_data    = '0;
    flush       = 1'b0;
    #2;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_way", resp_way, 0);
    chk("rst_evict_valid", evict_valid, 0);
    chk("rst_evict_tag", evict_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    @(negedge clk);
    gen_reset_n = 1'b1;

    fill(8'h12, 6'd3, 64'hDEADBEEF_CAFEF00D);
    chk("fill1_hit", r_hit, 0);
    chk("fill1_way", r_way, 0);
    chk("fill1_evict", r_ev, 0);
    rd(8'h12, 6'd3);
    chk("rd1_hit", r_hit, 1);
    chk("rd1_data", r_data, 64'hDEADBEEF_CAFEF00D);
    chk("rd1_way", r_way, 0);
    chk("rd1_evict", r_ev, 0);

    req(2'b01, 8'h12, 6'd3, 2'd2, 64'h0000_0000_0000_ABCD);
    chk("wr_hit", r_hit, 1);
    chk("wr_data_zero", r_data, 0);
    rd(8'h12, 6'd3);
    chk("wr_readback", r_data, 64'hDEADABCD_CAFEF00D);
    req(2'b01, 8'h13, 6'd3, 2'd1, 64'h0000_0000_0000_5555);
    chk("wr_miss_hit", r_hit, 0);
    rd(8'h13, 6'd3);
    chk("wr_miss_no_alloc", r_hit, 0);
    chk("wr_miss_rd_data", r_data, 0);
    req(2'b11, 8'h12, 6'd3, 2'd0, 64'd0);
    chk("rsvd_op_hit", r_hit, 1);
    chk("rsvd_op_data", r_data, 64'hDEADABCD_CAFEF00D);

    fill(8'h12, 6'd3, 64'h1111_2222_3333_4444);
    chk("fillhit_hit", r_hit, 1);
    chk("fillhit_way", r_way, 0);
    chk("fillhit_evict", r_ev, 0);
    rd(8'h12, 6'd3);
    chk("fillhit_data", r_data, 64'h1111_2222_3333_4444);

    for (int i = 0; i < 4; i++) begin
      fill(8'hA0 + 8'(i), 6'd5, 64'(i + 100));
      chk("set5_fill_way", r_way, 64'(i));
      chk("set5_fill_evict", r_ev, 0);
    end
    for (int i = 0; i < 3; i++) rd(8'hA2, 6'd5);
    chk("set5_rd_way2", r_way, 2);
    chk("set5_rd_data2", r_data, 102);
    rd(8'hA0, 6'd5);
    rd(8'hA1, 6'd5);
    rd(8'hA3, 6'd5);
    fill(8'hB0, 6'd5, 64'h0B0);
    chk("set5_evict_way", r_way, 0);
    chk("set5_evict_valid", r_ev, 1);
    chk("set5_evict_tag", r_evtag, 8'hA0);
    fill(8'hB1, 6'd5, 64'h0B1);
    chk("set5_evict2_way", r_way, 0);
    chk("set5_evict2_tag", r_evtag, 8'hB0);
    rd(8'hA0, 6'd5);
    chk("set5_a0_gone", r_hit, 0);
    rd(8'hA2, 6'd5);
    chk("set5_a2_kept", r_hit, 1);

    for (int i = 0; i < 4; i++) fill(8'hC0 + 8'(i), 6'd7, 64'(i));
    rd(8'hC1, 6'd7);
    rd(8'hC1, 6'd7);
    rd(8'hC2, 6'd7);
    rd(8'hC3, 6'd7);
    rd(8'hC3, 6'd7);
    for (int i = 0; i < 20; i++) rd(8'hC0, 6'd7);
    chk("sat_rd_hit", r_hit, 1);
    fill(8'hD0, 6'd7, 64'h0D0);
    chk("aging_victim_way", r_way, 1);
    chk("aging_evict_tag", r_evtag, 8'hC1);
    rd(8'hC0, 6'd7);
    chk("aging_c0_kept", r_hit, 1);

    @(negedge clk);
    req_op    = 2'b00;
    req_addr  = {8'h12, 6'd3};
    req_valid = 1'b1;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_busy", busy, 1);
    chk("flush_ready", req_ready, 0);
    flush = 1'b0;
    n = 0;
    seen = 1'b0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      if (resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("flush_len", 64'(n), 64);
    chk("flush_no_resp", seen, 0);
    chk("flush_ready_after", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp();
    chk("flush_held_req_miss", r_hit, 0);
    rd(8'hA2, 6'd5);
    chk("flush_set5_miss", r_hit, 0);
    rd(8'hC0, 6'd7);
    chk("flush_set7_miss", r_hit, 0);

    fill(8'h44, 6'd60, 64'h4444);
    rd(8'h44, 6'd60);
    chk("pre_rst_hit", r_hit, 1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    repeat (10) @(negedge clk);
    chk("midflush_busy", busy, 1);
    gen_reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_resp_valid", resp_valid, 0);
    chk("rst_mid_resp_hit", resp_hit, 0);
    @(negedge clk);
    gen_reset_n = 1'b1;
    #1;
    chk("rst_mid_ready", req_ready, 1);
    rd(8'h44, 6'd60);
    chk("rst_mid_miss", r_hit, 0);
    chk("rst_mid_data", r_data, 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
